// File: rtl/demux_slice.sv
// -----------------------------------------------------------------------------
// demux_slice
//
// Registered 1-to-2 demultiplexer. One valid/ready input stream is steered to
// one of two valid/ready output ports according to a per-word select bit. A
// single output register holds the word. The input can accept a new word in
// the same cycle the held word drains, so the slice sustains one word per
// cycle.
//
// Optional build macro: DEMUX_SLICE_CNT_EN
//   When defined, adds cnt1/cnt2: 16-bit wrapping counts of words drained on
//   port 1 and port 2.
//
// Ports:
//   clk         system clock, rising edge active
//   rst_n       asynchronous active-low reset
//   in_data     word offered by the producer
//   in_sel      destination: 0 -> port 1, 1 -> port 2
//   in_valid    producer has a word
//   in_ready    slice accepts the word this cycle
//   out1_data   held word (port 1 view)
//   out1_valid  port 1 has a word
//   out1_ready  port 1 consumer accepts
//   out2_data   held word (port 2 view)
//   out2_valid  port 2 has a word
//   out2_ready  port 2 consumer accepts
//   cnt1, cnt2  drain counters (DEMUX_SLICE_CNT_EN only)
//
// States:
//   state  | meaning
//   EMPTY  | no word held; in_ready = 1
//   FULL   | word held in data_q, destination in sel_q
// -----------------------------------------------------------------------------
module demux_slice #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready
`ifdef DEMUX_SLICE_CNT_EN
  ,
  output logic [15:0]      cnt1,
  output logic [15:0]      cnt2
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             full_q;
  logic             drain;
  logic             accept;

  assign full_q = (state_q == FULL);

  // Only the ready of the port that owns the held word can drain it.
  assign drain    = full_q & (sel_q ? out2_ready : out1_ready);
  assign in_ready = ~full_q | drain;
  assign accept   = in_valid & in_ready;

  assign out1_valid = full_q & ~sel_q;
  assign out2_valid = full_q &  sel_q;
  assign out1_data  = data_q;
  assign out2_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      sel_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;

    // Payload is only ever loaded on accept; an empty slice keeps the last word.
    if (accept) begin
      sel_d  = in_sel;
      data_d = in_data;
    end

    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        // drain & accept reloads in place, so there is no bubble.
        if (drain && !accept) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

`ifdef DEMUX_SLICE_CNT_EN
  logic [15:0] cnt1_q, cnt1_d;
  logic [15:0] cnt2_q, cnt2_d;

  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (drain && !sel_q) cnt1_d = cnt1_q + 16'd1;
    if (drain &&  sel_q) cnt2_d = cnt2_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1_q <= 16'd0;
      cnt2_q <= 16'd0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign cnt1 = cnt1_q;
  assign cnt2 = cnt2_q;
`endif

endmodule

// File: tb/tb_demux_slice.sv
module tb_demux_slice;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out2_data;
  logic             out2_valid;
  logic             out2_ready;
`ifdef DEMUX_SLICE_CNT_EN
  logic [15:0]      cnt1;
  logic [15:0]      cnt2;
`endif

  demux_slice #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready)
`ifdef DEMUX_SLICE_CNT_EN
    ,
    .cnt1       (cnt1),
    .cnt2       (cnt2)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of at most one pending word; the output data is
  // simply the most recently accepted word.
  typedef struct packed {
    logic             sel;
    logic [WIDTH-1:0] data;
  } word_t;

  word_t            mq[$];
  logic [WIDTH-1:0] m_last;
  logic [15:0]      m_cnt1, m_cnt2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_last = '0;
      m_cnt1 = '0;
      m_cnt2 = '0;
    end else begin
      logic m_drain, m_rdy;
      m_drain = (mq.size() != 0) && (mq[0].sel ? out2_ready : out1_ready);
      m_rdy   = (mq.size() == 0) || m_drain;
      if (m_drain) begin
        if (mq[0].sel) m_cnt2 = m_cnt2 + 16'd1;
        else           m_cnt1 = m_cnt1 + 16'd1;
        void'(mq.pop_front());
      end
      if (in_valid && m_rdy) begin
        mq.push_back('{sel: in_sel, data: in_data});
        m_last = in_data;
      end
    end
  end

  // Per-cycle comparison on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    logic e_v1, e_v2, e_rdy;
    e_v1  = (mq.size() != 0) && !mq[0].sel;
    e_v2  = (mq.size() != 0) &&  mq[0].sel;
    e_rdy = (mq.size() == 0) || (mq[0].sel ? out2_ready : out1_ready);
    chk("cyc_out1_valid", {31'd0, out1_valid}, {31'd0, e_v1});
    chk("cyc_out2_valid", {31'd0, out2_valid}, {31'd0, e_v2});
    chk("cyc_in_ready",   {31'd0, in_ready},   {31'd0, e_rdy});
    chk("cyc_out1_data",  out1_data, m_last);
    chk("cyc_out2_data",  out2_data, m_last);
`ifdef DEMUX_SLICE_CNT_EN
    chk("cyc_cnt1", {16'd0, cnt1}, {16'd0, m_cnt1});
    chk("cyc_cnt2", {16'd0, cnt2}, {16'd0, m_cnt2});
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = 32'hDEADBEEF;
    in_sel     = 1'b0;
    in_valid   = 1'b1;
    out1_ready = 1'b1;
    out2_ready = 1'b0;

    // Reset held with a word offered.
    repeat (3) step();
    chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    chk("rst_out2_valid", {31'd0, out2_valid}, 32'd0);
    chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
    chk("rst_out1_data",  out1_data, 32'd0);
    chk("rst_out2_data",  out2_data, 32'd0);

    // Release: the offered DEADBEEF is accepted at the next edge.
    rst_n = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    chk("single_out1_valid", {31'd0, out1_valid}, 32'd1);
    chk("single_out1_data",  out1_data, 32'hDEADBEEF);
    chk("single_out2_valid", {31'd0, out2_valid}, 32'd0);
    step();
    chk("single_drained", {31'd0, out1_valid}, 32'd0);

    // Backpressure on port 2; ready on port 1 must not drain it.
    in_data = 32'h5; in_sel = 1'b1; in_valid = 1'b1;
    out1_ready = 1'b1; out2_ready = 1'b0;
    step();
    in_data = 32'h6; in_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_out2_valid", {31'd0, out2_valid}, 32'd1);
      chk("bp_out2_data",  out2_data, 32'h5);
      chk("bp_in_ready",   {31'd0, in_ready}, 32'd0);
      chk("bp_out1_valid", {31'd0, out1_valid}, 32'd0);
      step();
    end
    in_valid = 1'b0;
    out2_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_drained", {31'd0, out2_valid}, 32'd0);

    // Streaming, alternating destinations, no bubbles.
    out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data  = 32'(i);
      in_sel   = (i % 2 == 0);
      in_valid = 1'b1;
      step();
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      if (i % 2 == 1) begin
        chk("stream_out1_valid", {31'd0, out1_valid}, 32'd1);
        chk("stream_out1_data",  out1_data, 32'(i));
      end else begin
        chk("stream_out2_valid", {31'd0, out2_valid}, 32'd1);
        chk("stream_out2_data",  out2_data, 32'(i));
      end
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_v1", {31'd0, out1_valid}, 32'd0);
    chk("stream_end_v2", {31'd0, out2_valid}, 32'd0);

    // Asynchronous reset while a word is stuck on port 1.
    in_data = 32'h77; in_sel = 1'b0; in_valid = 1'b1; out1_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("mid_held", {31'd0, out1_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_valid", {31'd0, out1_valid}, 32'd0);
    chk("mid_async_data",  out1_data, 32'd0);
    step();
    rst_n = 1'b1;
    out1_ready = 1'b1;
    repeat (3) begin
      step();
      chk("mid_no_redeliver", {31'd0, out1_valid | out2_valid}, 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = 1'($urandom_range(0, 1));
      in_data    = $urandom;
      out1_ready = ($urandom_range(0, 2) != 0);
      out2_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0;

`ifdef DEMUX_SLICE_CNT_EN
    // Counter wrap: 3 drains on port 1, 65537 on port 2.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out1_ready = 1'b1; out2_ready = 1'b1;
    in_valid = 1'b1;
    in_sel = 1'b0;
    repeat (3) step();
    in_sel = 1'b1;
    repeat (65537) step();
    in_valid = 1'b0;
    repeat (2) step();
    chk("cnt1_final", {16'd0, cnt1}, 32'd3);
    chk("cnt2_final", {16'd0, cnt2}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_slice.md
Name: demux_slice

Overview:
- Registered 1-to-2 demultiplexer: the inverse of the datapath 2:1 mux.
- Takes one valid/ready stream and steers each word to output port 1 or port 2 according to a per-word select bit.
- Single-entry output register; full throughput (one word per cycle).
- Used where one producer feeds two consumers, e.g. routing CPU store data to memory vs. the I/O register file.

Parameters:
- WIDTH, 32, data width in bits of the input and both output ports.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word offered by the producer.
- in_sel  input  1  destination select: 0 routes to port 1, 1 routes to port 2.
- in_valid  input  1  producer has a word on in_data/in_sel.
- in_ready  output  1  block accepts the word this cycle.
- out1_data  output  WIDTH  held word, port 1.
- out1_valid  output  1  port 1 has a word.
- out1_ready  input  1  port 1 consumer accepts.
- out2_data  output  WIDTH  held word, port 2.
- out2_valid  output  1  port 2 has a word.
- out2_ready  input  1  port 2 consumer accepts.

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- State:
  - full_q: entry occupied.
  - sel_q: destination of the held word.
  - data_q [WIDTH-1:0]: held word.
- Reset (rst_n=0, asynchronous): full_q=0, sel_q=0, data_q=0. Hence out1_valid=0, out2_valid=0, out1_data=out2_data=0, in_ready=1.
- Outputs:
  - out1_valid = full_q & ~sel_q; out2_valid = full_q & sel_q.
  - out1_data = out2_data = data_q on both ports at all times; consumers qualify with their own valid.
- Drain: drain = full_q & (sel_q ? out2_ready : out1_ready). A ready on the non-selected port has no effect.
- Accept:
  - in_ready = ~full_q | drain. Purely combinational from full_q, sel_q and the out*_ready inputs; no dependence on in_valid.
  - accept = in_valid & in_ready.
- State machine (full_q), transitions per rising edge:
  - EMPTY -> FULL on accept; data_q<=in_data, sel_q<=in_sel.
  - FULL -> EMPTY on drain & ~accept.
  - FULL -> FULL on drain & accept (simultaneous): new word loaded, no bubble. The destination may change word to word.
  - FULL -> FULL on ~drain: data_q and sel_q stable; in_ready=0 (backpressure).
- Latency: a word accepted at edge N is visible on the out port after edge N. Minimum in-to-out latency is 1 cycle.
- Stability: once out*_valid is 1, it and data_q hold until the corresponding ready is seen. A valid is never withdrawn except by reset.
- data_q and sel_q update only on accept. When empty they keep their last value.
- Reset mid-transfer: the held word is discarded silently; no output valid is asserted after reset release until a new accept.
- No ordering hazard: words leave strictly in acceptance order, because there is a single entry.

Optional Feature:
- Macro DEMUX_SLICE_CNT_EN.
- Defined:
  - Adds output ports cnt1 and cnt2, each 16 bits, counting completed drains on port 1 and port 2.
  - Each counter increments by 1 on a drain to its port and wraps 16'hFFFF -> 16'h0000.
  - Both counters reset to 0 on rst_n=0.
- Undefined: ports and counter logic are absent. The remaining behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out1_valid=out2_valid=0, in_ready=1, out*_data=0. Release -> first accept occurs at the next edge.
- Single word: in_data=32'hDEADBEEF, in_sel=0, in_valid=1 for one cycle, out1_ready=1 -> next cycle out1_valid=1, out1_data=DEADBEEF, out2_valid=0. Following cycle out1_valid=0.
- Backpressure: in_sel=1, word 32'h5, out2_ready=0 for 4 cycles -> out2_valid=1, data stable at 5, in_ready=0 throughout. Ready on out1 ignored. Raise out2_ready -> drained in 1 cycle.
- Streaming alternating destinations: words 1,2,3,4 with sel 0,1,0,1 back-to-back, both readies=1 -> one word per cycle, 1→port1, 2→port2, 3→port1, 4→port2, no bubbles.
- Reset mid-operation: word held with out1_ready=0, assert rst_n=0 asynchronously mid-cycle -> out1_valid falls immediately without a clock edge. The word is never delivered.
- DEMUX_SLICE_CNT_EN: 3 drains to port1, 65537 drains to port2 -> cnt1=3, cnt2=1 (wrapped).
